pi_loop_ctrl: RTL and testbench

PI_LOOP_CTRL -- requirements
Module: pi_loop_ctrl

---
 rtl/pi_loop_ctrl.sv | 143 ++++++++++++++
 tb/tb_pi_loop_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pi_loop_ctrl.sv
// PI controller for the dither lock loop: each demodulated error sample runs
// through a five-state pipeline (latch, shift gains, integrate, sum, clamp out).
module pi_loop_ctrl #(
  parameter int SHIFT_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_trig,
  input  logic signed [31:0]  i_err,
  input  logic                i_loop_en,
  input  logic [SHIFT_W-1:0]  i_kp_shift,
  input  logic [SHIFT_W-1:0]  i_ki_shift,
  input  logic [31:0]         i_int_limit,
  input  logic [31:0]         i_out_limit,
  output logic signed [31:0]  o_ctrl,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_int_sat,
  output logic                o_out_sat,
  output logic                o_ovf,
  output logic [2:0]          o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_INTEG = 3'd2,
    S_SUM   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t              state;
  logic signed [31:0]  err_q;
  logic signed [31:0]  p_q;
  logic signed [31:0]  step_q;
  logic signed [31:0]  integ_q;
  logic signed [32:0]  sum_q;

  // Shifts of 31 or more saturate to the sign fill (0 or -1).
  function automatic logic signed [31:0] sra(input logic signed [31:0] v,
                                             input logic [SHIFT_W-1:0] sh);
    logic [31:0] sh32;
    sh32 = 32'(sh);
    if (sh32 >= 32'd31) return v >>> 31;
    else                return v >>> sh32[4:0];
  endfunction

  // Limits are magnitudes up to 2^31-1, so -limit always fits in 32 bits.
  logic signed [32:0] int_hi, int_lo, int_sum, int_clamped;
  logic signed [32:0] out_hi, out_lo, out_clamped;
  logic               int_clip, out_clip;
  logic               unused_lim_msb;

  assign unused_lim_msb = i_int_limit[31] ^ i_out_limit[31];

  always_comb begin
    int_hi  = {2'b00, i_int_limit[30:0]};
    int_lo  = -int_hi;
    int_sum = {integ_q[31], integ_q} + {step_q[31], step_q};
    int_clip    = 1'b0;
    int_clamped = int_sum;
    if (int_sum > int_hi) begin
      int_clamped = int_hi;
      int_clip    = 1'b1;
    end else if (int_sum < int_lo) begin
      int_clamped = int_lo;
      int_clip    = 1'b1;
    end

    out_hi = {2'b00, i_out_limit[30:0]};
    out_lo = -out_hi;
    out_clip    = 1'b0;
    out_clamped = sum_q;
    if (sum_q > out_hi) begin
      out_clamped = out_hi;
      out_clip    = 1'b1;
    end else if (sum_q < out_lo) begin
      out_clamped = out_lo;
      out_clip    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      err_q     <= '0;
      p_q       <= '0;
      step_q    <= '0;
      integ_q   <= '0;
      sum_q     <= '0;
      o_ctrl    <= '0;
      o_valid   <= 1'b0;
      o_int_sat <= 1'b0;
      o_out_sat <= 1'b0;
      o_ovf     <= 1'b0;
    end else if (!i_loop_en) begin
      // Opening the loop abandons any sample in flight and zeroes the output.
      state     <= S_IDLE;
      integ_q   <= '0;
      o_ctrl    <= '0;
      o_valid   <= 1'b0;
      o_int_sat <= 1'b0;
      o_out_sat <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_trig && state != S_IDLE) o_ovf <= 1'b1;
      case (state)
        S_IDLE: begin
          if (i_trig) begin
            err_q <= i_err;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          p_q    <= sra(err_q, i_kp_shift);
          step_q <= sra(err_q, i_ki_shift);
          state  <= S_INTEG;
        end
        S_INTEG: begin
          integ_q   <= int_clamped[31:0];
          o_int_sat <= int_clip;
          state     <= S_SUM;
        end
        S_SUM: begin
          sum_q <= {p_q[31], p_q} + {integ_q[31], integ_q};
          state <= S_OUT;
        end
        S_OUT: begin
          o_ctrl    <= out_clamped[31:0];
          o_out_sat <= out_clip;
          o_valid   <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_pi_loop_ctrl.sv
// Directed bench for pi_loop_ctrl: a vector table of trigger results plus
// hand-written sequences for overflow, loop-open, reset abort and back-to-back.
module tb_pi_loop_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               trig;
  logic signed [31:0] err;
  logic               loop_en;
  logic [4:0]         kp, ki;
  logic [31:0]        int_lim, out_lim;
  logic signed [31:0] ctrl;
  logic               valid, busy, int_sat, out_sat, ovf;
  logic [2:0]         state;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  pi_loop_ctrl #(.SHIFT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_trig(trig), .i_err(err), .i_loop_en(loop_en),
    .i_kp_shift(kp), .i_ki_shift(ki), .i_int_limit(int_lim), .i_out_limit(out_lim),
    .o_ctrl(ctrl), .o_valid(valid), .o_busy(busy), .o_int_sat(int_sat),
    .o_out_sat(out_sat), .o_ovf(ovf), .o_state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        clr;
    logic [31:0] err;
    logic [4:0]  kp, ki;
    logic [31:0] il, ol;
    logic [31:0] exp_ctrl;
    logic        exp_isat, exp_osat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic start(input logic [31:0] e);
    err  = e;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 12);
    if (!valid) n = -1;
  endtask

  task automatic expect_no_valid(input string nm, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check(nm, 32'(seen), 32'd0);
  endtask

  task automatic open_loop();
    @(negedge clk);
    loop_en = 1'b0;
    @(negedge clk);
    loop_en = 1'b1;
  endtask

  task automatic set_gains(input logic [4:0] p, input logic [4:0] i,
                           input logic [31:0] il, input logic [31:0] ol);
    kp = p; ki = i; int_lim = il; out_lim = ol;
  endtask

  task automatic run_one(input string nm, input logic [31:0] e, input logic [31:0] exp);
    int n;
    @(negedge clk);
    start(e);
    wait_valid(n);
    check({nm, "_lat"}, 32'(n), 32'd4);
    check({nm, "_ctrl"}, ctrl, exp);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'd3100,  5'd2,  5'd4,  32'd100000, 32'd100000, 32'd968,   1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'd3100,  5'd2,  5'd4,  32'd100000, 32'd100000, 32'd1161,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, -32'sd3100, 5'd2, 5'd4,  32'd100000, 32'd100000, -32'sd969, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'd3100,  5'd2,  5'd4,  32'd500,    32'd100000, 32'd968,   1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'd3100,  5'd2,  5'd4,  32'd500,    32'd100000, 32'd1161,  1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'd3100,  5'd2,  5'd4,  32'd500,    32'd100000, 32'd1275,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'd3100,  5'd2,  5'd4,  32'd500,    32'd100000, 32'd1275,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'd3100,  5'd2,  5'd4,  32'd100000, 32'd800,    32'd800,   1'b0, 1'b1};
    vecs[8]  = '{1'b1, -32'sd3100, 5'd2, 5'd4,  32'd100000, 32'd800,    -32'sd800, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'd5,     5'd31, 5'd31, 32'd100000, 32'd100000, 32'd0,     1'b0, 1'b0};
    vecs[10] = '{1'b1, -32'sd5,   5'd31, 5'd31, 32'd100000, 32'd100000, -32'sd2,   1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'd3100,  5'd2,  5'd4,  32'd0,      32'd0,      32'd0,     1'b1, 1'b1};
    vecs[12] = '{1'b1, 32'h7fffffff, 5'd0, 5'd0, 32'hffffffff, 32'hffffffff, 32'h7fffffff, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'h80000000, 5'd0, 5'd0, 32'hffffffff, 32'hffffffff, 32'h80000001, 1'b1, 1'b1};

    rst = 1'b1; trig = 1'b0; err = '0; loop_en = 1'b1;
    set_gains(5'd2, 5'd4, 32'd100000, 32'd100000);
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl, 32'd0);
    check("rst_flags", {27'd0, valid, busy, int_sat, out_sat, ovf}, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      if (vecs[v].clr) open_loop();
      set_gains(vecs[v].kp, vecs[v].ki, vecs[v].il, vecs[v].ol);
      @(negedge clk);
      start(vecs[v].err);
      check($sformatf("v%0d_busy", v), {29'd0, state == 3'd1, busy, 1'b0}, 32'd6);
      wait_valid(n);
      check($sformatf("v%0d_lat", v), 32'(n), 32'd4);
      check($sformatf("v%0d_ctrl", v), ctrl, vecs[v].exp_ctrl);
      check($sformatf("v%0d_sat", v), {30'd0, int_sat, out_sat},
            {30'd0, vecs[v].exp_isat, vecs[v].exp_osat});
      @(negedge clk);
      check($sformatf("v%0d_pulse", v), {30'd0, valid, busy}, 32'd0);
    end

    // Opening the loop clears output and flags.
    open_loop();
    check("open_clear", {ctrl[27:0], int_sat, out_sat, ovf, valid}, 32'd0);

    // Trigger two cycles after an accepted one: ignored, sticky overflow.
    set_gains(5'd2, 5'd4, 32'd100000, 32'd100000);
    @(negedge clk);
    start(32'd3100);
    @(negedge clk);
    start(-32'sd9999);
    wait_valid(n);
    check("ovf_lat", 32'(n), 32'd2);
    check("ovf_ctrl", ctrl, 32'd968);
    check("ovf_flag", 32'(ovf), 32'd1);
    expect_no_valid("ovf_extra_valid", 8);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Back-to-back triggers exactly five cycles apart.
    open_loop();
    check("open_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    start(32'd3100);
    wait_valid(n);
    check("b2b_ctrl0", ctrl, 32'd968);
    start(32'd3100);
    wait_valid(n);
    check("b2b_lat", 32'(n), 32'd4);
    check("b2b_ctrl1", ctrl, 32'd1161);
    check("b2b_ovf", 32'(ovf), 32'd0);

    // Loop opened during SUM aborts and clears integrator.
    @(negedge clk);
    start(32'd3100);
    @(negedge clk);
    @(negedge clk);
    check("sum_state", 32'(state), 32'd3);
    loop_en = 1'b0;
    @(negedge clk);
    loop_en = 1'b1;
    check("sum_abort_state", 32'(state), 32'd0);
    check("sum_abort_ctrl", ctrl, 32'd0);
    expect_no_valid("sum_abort_valid", 8);
    run_one("sum_after", 32'd3100, 32'd968);

    // Reset pulsed during INTEG aborts asynchronously.
    @(negedge clk);
    start(32'd3100);
    @(negedge clk);
    check("integ_state", 32'(state), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_ctrl", ctrl, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_no_valid("rst_abort_valid", 8);
    run_one("rst_after", 32'd3100, 32'd968);

    // Trigger ignored while the loop is open.
    @(negedge clk);
    loop_en = 1'b0;
    start(32'd3100);
    loop_en = 1'b1;
    check("open_trig_state", 32'(state), 32'd0);
    expect_no_valid("open_trig_valid", 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
